mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit, sitting between the register-file read ports and its write port.
- Takes rs1/rs2 values (RD1/RD2), computes over multiple cycles, then writes the result back through the register-file write port (WD3/Address3/WriteEnable3).
- Stalls the core via Busy while computing.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- ITERS, 32, shift/subtract iterations per operation; must equal XLEN.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Funct3  input  3  operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Op_A  input  32  rs1 value (RD1).
- Op_B  input  32  rs2 value (RD2).
- Rd_In  input  5  destination register index.
- Busy  output  1  high from the cycle after Start is accepted through the DONE cycle inclusive; core stalls on it.
- Done  output  1  one-cycle pulse; result valid.
- WriteEnable  output  1  equals Done; drives register file WriteEnable3.
- Result  output  32  drives WD3; valid when Done=1.
- Rd_Out  output  5  drives Address3; latched Rd_In.

Behaviour:
- Reset (async, rst=1): state IDLE; Busy=0, Done=0, WriteEnable=0, Result=0, Rd_Out=0; all internal registers cleared.
- Reset mid-operation aborts the operation with no Done and no write.
- States: IDLE, CALC, DONE.
- IDLE:
  - Start=1 latches Funct3, Rd_In, |Op_A| and |Op_B| (absolute value only for signed operands per Funct3), plus sign flags.
  - Clears counter; next state CALC.
- CALC:
  - One iteration per cycle; counter 0..ITERS-1.
  - Multiply: radix-2 shift-add into a 64-bit unsigned product.
  - Divide: restoring, 32-bit quotient/remainder.
  - After iteration ITERS-1, next state DONE.
- DONE:
  - Done=1, WriteEnable=1, Result registered, next state IDLE.
  - Start in this cycle is ignored.
- Latency: Start sampled at edge N → Done high during cycle N+ITERS+1 (33 cycles after acceptance). Back-to-back: next Start accepted at the edge after DONE.
- Start while not IDLE is ignored; operands/Rd are not re-latched.
- Sign fix (applied when producing Result):
  - Product negated if signs differ (MULH: both signed; MULHSU: Op_A only).
  - Quotient negated if signs differ; remainder takes Op_A's sign.
- Result selection:
  - MUL → product[31:0].
  - MULH/MULHSU/MULHU → product[63:32].
  - DIV/DIVU → quotient; REM/REMU → remainder.
- Divide by zero: quotient = 32'hFFFFFFFF and remainder = Op_A for both signed and unsigned; quotient sign fix suppressed.
- Signed overflow (DIV 32'h80000000 / 32'hFFFFFFFF): quotient 32'h80000000, REM 0. The natural abs/negate path yields this; no special case is needed.
- Rd_Out=0: WriteEnable still pulses; the register file discards writes to x0.
- No exceptions raised.

Optional Feature:
- MDU_ZERO_SHORTCUT_EN defined:
  - In IDLE, if Op_B==0 (any op) or Op_A==0 (any op), skip CALC and go straight to DONE.
  - Done appears in cycle N+1. Result per the rules above: 0 for multiply; divide-by-zero values; 0 quotient/remainder for zero dividend.
- Undefined: fixed latency for all operands.

Decomposition:
- Package mdu_pkg:
  - Funct3 localparams (F3_MUL … F3_REMU).
  - State encoding (S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2).
  - ITERS default.
  - Helper function is_signed_a/is_signed_b(funct3).
- One natural sub-module: mdu_div_step, the combinational restoring-divide step (remainder/quotient shift, trial subtract, select), instantiated in CALC.
- Multiply step stays inline.

Test Plan:
- Reset mid-op: Start MUL, assert rst at cycle 10 → Busy=0, Done never pulses, Result=0, Rd_Out=0; next Start completes normally.
- MUL / MULHU: Op_A=32'hFFFFFFFF, Op_B=32'hFFFFFFFF, Rd_In=5.
  - MULHU → Result 32'hFFFFFFFE; MUL → 32'h00000001.
  - Done exactly 33 cycles after Start; Rd_Out=5, WriteEnable=1 for one cycle.
- MULH / MULHSU: Op_A=-2 (32'hFFFFFFFE), Op_B=3.
  - MULH → 32'hFFFFFFFF.
  - MULHSU with Op_A=-2, Op_B=32'hFFFFFFFF → 32'hFFFFFFFE.
- DIV/REM signs: Op_A=-7, Op_B=2.
  - DIV → 32'hFFFFFFFD (-3); REM → 32'hFFFFFFFF (-1).
  - DIVU 7/2 → 3; REMU → 1.
- Corner cases:
  - DIV 32'h80000000/-1 → 32'h80000000; REM → 0.
  - DIV -5/0 → 32'hFFFFFFFF; REM -5/0 → 32'hFFFFFFFB; DIVU 9/0 → 32'hFFFFFFFF.
  - With MDU_ZERO_SHORTCUT_EN, Done follows Start by 1 cycle.
- Start while Busy: pulse Start with new operands at cycle 5 of an operation → ignored; first result unchanged; a new Start after Done is accepted.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - Funct3 operation codes (F3_MUL .. F3_REMU)
//   - FSM state encoding (S_IDLE, S_CALC, S_DONE)
//   - default operand width and iteration count
//   - helpers telling which operands are treated as signed for a given Funct3
// -----------------------------------------------------------------------------
package mdu_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int ITERS_DEF = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // MUL only keeps the low half, which is identical for signed and unsigned
   // operands, so it is handled as unsigned.
   function automatic logic is_signed_a(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// -----------------------------------------------------------------------------
// mdu_div_step
// One combinational iteration of an unsigned restoring divider.
// The partial remainder is shifted left taking in the next dividend bit, the
// divisor is trial-subtracted, and the remainder is restored when the trial
// borrows. The dividend register doubles as the quotient register: each step
// shifts one dividend bit out of the top and one quotient bit into the bottom.
//
// Ports:
//   rem_i     [XLEN-1:0]  partial remainder before this step
//   quo_i     [XLEN-1:0]  remaining dividend bits / quotient bits so far
//   divisor_i [XLEN-1:0]  unsigned divisor
//   rem_o     [XLEN-1:0]  partial remainder after this step
//   quo_o     [XLEN-1:0]  dividend/quotient register after this step
// -----------------------------------------------------------------------------
module mdu_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // The shifted remainder needs one extra bit; since rem_i < divisor_i the
   // non-borrowing difference always fits back into XLEN bits.
   assign shifted = {rem_i, quo_i[XLEN-1]};
   assign diff    = shifted - {1'b0, divisor_i};

   assign rem_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative RV32M multiply/divide unit placed between the register-file read
// ports (RD1/RD2) and its write port (WD3/Address3/WriteEnable3).
// Operands are converted to magnitudes on acceptance, one shift-add (multiply)
// or restoring-subtract (divide) iteration runs per cycle for ITERS cycles,
// then the sign-corrected result is registered and written back for one cycle.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset; aborts any operation in flight
//   Start        request, sampled only while idle
//   Funct3 [2:0] MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   Op_A   [31:0] rs1 value, Op_B [31:0] rs2 value
//   Rd_In  [4:0]  destination register index
//   Busy         high from the cycle after acceptance through the Done cycle
//   Done         one-cycle pulse, Result valid
//   WriteEnable  equals Done (register-file WriteEnable3)
//   Result [31:0] register-file WD3
//   Rd_Out [4:0]  register-file Address3 (latched Rd_In)
//
// Build option:
//   MDU_ZERO_SHORTCUT_EN  when defined, an operation with Op_A==0 or Op_B==0
//                         skips the iterations and completes one cycle after
//                         acceptance. Undefined: fixed latency.
// -----------------------------------------------------------------------------
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int ITERS = ITERS_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            Start,
   input  logic [2:0]      Funct3,
   input  logic [XLEN-1:0] Op_A,
   input  logic [XLEN-1:0] Op_B,
   input  logic [4:0]      Rd_In,
   output logic            Busy,
   output logic            Done,
   output logic            WriteEnable,
   output logic [XLEN-1:0] Result,
   output logic [4:0]      Rd_Out
);

   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [2:0]          f3_q,    f3_d;
   logic [4:0]          rd_q,    rd_d;
   // |Op_A| (multiplicand) for multiplies, |Op_B| (divisor) for divides.
   logic [XLEN-1:0]     opnd_q,  opnd_d;
   // Multiply: {partial product high, multiplier / product low}.
   // Divide:   {partial remainder, dividend / quotient}.
   logic [2*XLEN-1:0]   acc_q,   acc_d;
   logic                sa_q,    sa_d;
   logic                sb_q,    sb_d;
   logic                bz_q,    bz_d;
   logic [XLEN-1:0]     res_q,   res_d;

   logic                a_sgn, b_sgn;
   logic [XLEN-1:0]     abs_a, abs_b;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN-1:0]     div_rem, div_quo;
   logic [2*XLEN-1:0]   step_next;

   // Sign correction and result selection from the final magnitudes.
   function automatic logic [XLEN-1:0] finalize(input logic [2:0]        f3,
                                                input logic [2*XLEN-1:0] acc,
                                                input logic              sa,
                                                input logic              sb,
                                                input logic              bz);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quo;
      logic [XLEN-1:0]   rem;
      prod = (sa ^ sb) ? -acc : acc;
      // Divide by zero keeps the all-ones quotient regardless of signs.
      quo  = ((sa ^ sb) && !bz) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      // Remainder follows the dividend; this also restores Op_A on divide by zero.
      rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (f3)
         F3_MUL:                       finalize = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: finalize = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              finalize = quo;
         default:                      finalize = rem;
      endcase
   endfunction

`ifdef MDU_ZERO_SHORTCUT_EN
   // Result when either operand is zero: multiplies give 0, a zero divisor
   // gives all-ones quotient / dividend remainder, a zero dividend gives 0.
   function automatic logic [XLEN-1:0] shortcut(input logic [2:0]      f3,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      if (!f3[2])
         return '0;
      if (b == '0)
         return f3[1] ? a : '1;
      return '0;
   endfunction
`endif

   assign a_sgn = is_signed_a(Funct3) & Op_A[XLEN-1];
   assign b_sgn = is_signed_b(Funct3) & Op_B[XLEN-1];
   assign abs_a = a_sgn ? -Op_A : Op_A;
   assign abs_b = b_sgn ? -Op_B : Op_B;

   // Radix-2 shift-add: add the multiplicand into the high half when the
   // current multiplier bit is set, then shift the whole accumulator right.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   mdu_div_step #(
      .XLEN (XLEN)
   ) u_div_step (
      .rem_i     (acc_q[2*XLEN-1:XLEN]),
      .quo_i     (acc_q[XLEN-1:0]),
      .divisor_i (opnd_q),
      .rem_o     (div_rem),
      .quo_o     (div_quo)
   );

   assign step_next = f3_q[2] ? {div_rem, div_quo} : mul_next;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      rd_d    = rd_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      bz_d    = bz_q;
      res_d   = res_q;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               f3_d  = Funct3;
               rd_d  = Rd_In;
               sa_d  = a_sgn;
               sb_d  = b_sgn;
               bz_d  = (Op_B == '0);
               cnt_d = '0;
               if (Funct3[2]) begin
                  opnd_d = abs_b;
                  acc_d  = {{XLEN{1'b0}}, abs_a};
               end else begin
                  opnd_d = abs_a;
                  acc_d  = {{XLEN{1'b0}}, abs_b};
               end
               state_d = S_CALC;
`ifdef MDU_ZERO_SHORTCUT_EN
               if ((Op_A == '0) || (Op_B == '0)) begin
                  res_d   = shortcut(Funct3, Op_A, Op_B);
                  state_d = S_DONE;
               end
`endif
            end
         end

         S_CALC: begin
            acc_d = step_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(ITERS - 1)) begin
               res_d   = finalize(f3_q, step_next, sa_q, sb_q, bz_q);
               state_d = S_DONE;
            end
         end

         // Start is not looked at here; the next request is taken in IDLE.
         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         bz_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         bz_q    <= bz_d;
         res_q   <= res_d;
      end
   end

   assign Busy        = (state_q != S_IDLE);
   assign Done        = (state_q == S_DONE);
   assign WriteEnable = Done;
   assign Result      = res_q;
   assign Rd_Out      = rd_q;

endmodule
